// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and FSM encoding for the cipher round stages.
// Latency: n/a (package). Backpressure: n/a.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam int COL_W    = 32;
    localparam int NUM_COLS = 4;

    // Byte lane of each row inside a column word: row0 sits in [31:24].
    localparam int LANE_ROW0 = 3;
    localparam int LANE_ROW1 = 2;
    localparam int LANE_ROW2 = 1;
    localparam int LANE_ROW3 = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mix_column.sv
// MixColumns on one 32-bit column over GF(2^8).
// Latency: combinational. Backpressure: none.
module gf_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    always_comb begin
        a0 = col_i[LANE_ROW0*8 +: 8];
        a1 = col_i[LANE_ROW1*8 +: 8];
        a2 = col_i[LANE_ROW2*8 +: 8];
        a3 = col_i[LANE_ROW3*8 +: 8];

        // 3x = xtime(x) ^ x
        r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);

        col_o = 32'h0;
        col_o[LANE_ROW0*8 +: 8] = r0;
        col_o[LANE_ROW1*8 +: 8] = r1;
        col_o[LANE_ROW2*8 +: 8] = r2;
        col_o[LANE_ROW3*8 +: 8] = r3;
    end

endmodule

// File: rtl/mix_columns_iter.sv
// AES MixColumns stage, one column per cycle through a shared mixer; final round bypasses.
// Latency: accept->out_valid 5 cycles (bypass 1). Backpressure: holds result until out_ready, in_ready=0 meanwhile.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 32  // only 32 is meaningful: 4 rows x 8 bits
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last_round,
    input  logic [DATA_WIDTH-1:0] in_mc0,
    input  logic [DATA_WIDTH-1:0] in_mc1,
    input  logic [DATA_WIDTH-1:0] in_mc2,
    input  logic [DATA_WIDTH-1:0] in_mc3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_mc0,
    output logic [DATA_WIDTH-1:0] out_mc1,
    output logic [DATA_WIDTH-1:0] out_mc2,
    output logic [DATA_WIDTH-1:0] out_mc3
);

    mc_state_e                             state_q, state_d;
    logic [1:0]                            col_cnt_q, col_cnt_d;
    logic                                  last_q, last_d;
    logic                                  out_valid_q, out_valid_d;
    logic [NUM_COLS-1:0][DATA_WIDTH-1:0]   src_q, src_d;
    logic [NUM_COLS-1:0][DATA_WIDTH-1:0]   res_q, res_d;
    logic [DATA_WIDTH-1:0]                 mix_in, mix_out;
    logic                                  accept;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign mix_in   = src_q[col_cnt_q];

    gf_mix_column u_mix (
        .col_i (mix_in),
        .col_o (mix_out)
    );

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        src_d       = src_q;
        res_d       = res_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    src_d     = {in_mc3, in_mc2, in_mc1, in_mc0};
                    last_d    = in_last_round;
                    col_cnt_d = 2'd0;
                    state_d   = in_last_round ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                res_d[col_cnt_q] = mix_out;
                col_cnt_d        = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result presentation lags DONE entry by one edge, so the bypass copy lands with out_valid.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    if (last_q) begin
                        res_d = src_q;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= 2'd0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            src_q       <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            src_q       <= src_d;
            res_q       <= res_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mc0   = res_q[0];
    assign out_mc1   = res_q[1];
    assign out_mc2   = res_q[2];
    assign out_mc3   = res_q[3];

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter with hand-computed AES MixColumns vectors.
module tb_mix_columns_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_last_round;
    logic [31:0] in_mc0, in_mc1, in_mc2, in_mc3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mc0, out_mc1, out_mc2, out_mc3;

    int total = 0;
    int bad   = 0;

    logic [127:0] held;

    always #5 clk = ~clk;

    mix_columns_iter #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last_round (in_last_round),
        .in_mc0        (in_mc0),
        .in_mc1        (in_mc1),
        .in_mc2        (in_mc2),
        .in_mc3        (in_mc3),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mc0       (out_mc0),
        .out_mc1       (out_mc1),
        .out_mc2       (out_mc2),
        .out_mc3       (out_mc3)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {out_mc0, out_mc1, out_mc2, out_mc3};
    endfunction

    // Drive one state; returns #1 after the accepting edge with garbage on the inputs.
    task automatic send(input logic [31:0] a, b, c, d, input logic last);
        @(negedge clk);
        in_valid = 1'b1; in_last_round = last;
        in_mc0 = a; in_mc1 = b; in_mc2 = c; in_mc3 = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last_round = ~last;
        in_mc0 = 32'hA5A5A5A5; in_mc1 = 32'h5A5A5A5A; in_mc2 = 32'hFFFFFFFF; in_mc3 = 32'h12345678;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_ready_back"}, {127'd0, in_ready}, 128'd1);
    endtask

    task automatic run_mix(input string tag, input logic [127:0] din, input logic [127:0] exp);
        send(din[127:96], din[95:64], din[63:32], din[31:0], 1'b0);
        edges(3);
        chk({tag, "_busy_noready"}, {127'd0, in_ready}, 128'd0);
        edges(1);
        chk({tag, "_valid_early"}, {127'd0, out_valid}, 128'd0);
        edges(1);
        chk({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
        chk({tag, "_data"}, outs(), exp);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last_round = 1'b0; out_ready = 1'b0;
        in_mc0 = '0; in_mc1 = '0; in_mc2 = '0; in_mc3 = '0;
        edges(2);
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_data", outs(), 128'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

        // Single non-trivial column
        run_mix("col", {32'hDB135345, 96'd0}, {32'h8E4DA1BC, 96'd0});
        handshake("col");
        chk("col_hold", outs(), {32'h8E4DA1BC, 96'd0});

        // FIPS-197 Appendix B, round 1
        run_mix("fips", {32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5},
                        {32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c});
        handshake("fips");

        // Bypass for the final round
        send(32'hCAFEBABE, 32'h00000000, 32'hFFFFFFFF, 32'h80000001, 1'b1);
        chk("byp_noready", {127'd0, in_ready}, 128'd0);
        chk("byp_valid_early", {127'd0, out_valid}, 128'd0);
        edges(1);
        chk("byp_valid", {127'd0, out_valid}, 128'd1);
        chk("byp_data", outs(), {32'hCAFEBABE, 32'h00000000, 32'hFFFFFFFF, 32'h80000001});
        edges(2);
        chk("byp_hold_noready", {127'd0, in_ready}, 128'd0);
        handshake("byp");

        // Backpressure while a competing state is offered
        run_mix("bp", {32'h01010101, 32'hC6C6C6C6, 32'hD4D4D4D5, 32'h2D26314C},
                      {32'h01010101, 32'hC6C6C6C6, 32'hD5D5D7D6, 32'h4D7EBDF8});
        held = {32'h01010101, 32'hC6C6C6C6, 32'hD5D5D7D6, 32'h4D7EBDF8};
        @(negedge clk);
        in_valid = 1'b1; in_last_round = 1'b1;
        in_mc0 = 32'h11111111; in_mc1 = 32'h22222222; in_mc2 = 32'h33333333; in_mc3 = 32'h44444444;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("bp_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_stable", outs(), held);
            chk("bp_noready", {127'd0, in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        handshake("bp");
        edges(2);
        chk("bp_no_accept", {127'd0, out_valid}, 128'd0);
        chk("bp_idle", {127'd0, in_ready}, 128'd1);
        chk("bp_hold", outs(), held);

        // Reset during BUSY with col_cnt at 2
        send(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 1'b0);
        edges(2);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_rst_data", outs(), 128'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", {127'd0, in_ready}, 128'd1);
        run_mix("rerun", {32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5},
                         {32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c});
        handshake("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
